clock_phase_gen: RTL and testbench

Parametrised, synchronous successor to the four-phase W/X/Y/Z clock drivers. From a single master clock it sequences NPHASE mutually exclusive phase enables separated by programmable dead time, which guarantees non-overlap by construction. It also counts bit times within a word, supports run, stop-at-bit-boundary and single-step control, and replicates each phase onto FANOUT buffered copies plus an inverted copy. It feeds the timing inputs of the arithmetic, memory and I/O sections.

---
 rtl/clock_phase_gen_pkg.sv | 44 ++++
 rtl/clock_phase_gen_fanout.sv | 43 ++++
 rtl/clock_phase_gen.sv | 132 +++++++++++++
 tb/tb_clock_phase_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_phase_gen_pkg.sv
// Shared types, width helpers and legality ranges for the phase sequencer.
// The module parameters drive the actual widths; the defaults are exported for users.
package clock_phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACT  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int NPHASE_MIN    = 2;
  localparam int NPHASE_MAX    = 8;
  localparam int PHASE_CYC_MIN = 1;
  localparam int GAP_CYC_MIN   = 1;
  localparam int BIT_TIMES_MIN = 2;
  localparam int FANOUT_MIN    = 1;

  function automatic int bit_w(input int bit_times);
    return $clog2(bit_times);
  endfunction

  // Cycle counter must hold the larger of the two phase lengths.
  function automatic int cnt_w(input int phase_cyc, input int gap_cyc);
    int m;
    m = (phase_cyc > gap_cyc) ? phase_cyc : gap_cyc;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_w(input int nphase);
    return $clog2(nphase);
  endfunction

  function automatic bit params_ok(input int nphase, input int phase_cyc,
                                   input int gap_cyc, input int bit_times,
                                   input int fanout);
    return (nphase >= NPHASE_MIN) && (nphase <= NPHASE_MAX) &&
           (phase_cyc >= PHASE_CYC_MIN) && (gap_cyc >= GAP_CYC_MIN) &&
           (bit_times >= BIT_TIMES_MIN) && (fanout >= FANOUT_MIN);
  endfunction

  localparam int BW_DEFAULT = bit_w(14);
  localparam int CW_DEFAULT = cnt_w(3, 1);

endpackage

// File: rtl/clock_phase_gen_fanout.sv
// Registers the next-cycle phase vector into PH, PHN and the replicated PH_FAN
// copies together, so every copy switches on the same edge as PH.
module phase_fanout #(
  parameter int NPHASE = 4,
  parameter int FANOUT = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NPHASE-1:0]        ph_d,
  output logic [NPHASE-1:0]        ph,
  output logic [NPHASE-1:0]        phn,
  output logic [NPHASE*FANOUT-1:0] ph_fan
);

  logic [NPHASE-1:0]        ph_q, phn_q;
  logic [NPHASE*FANOUT-1:0] fan_q, fan_d;

  always_comb begin
    fan_d = '0;
    for (int k = 0; k < NPHASE; k++) begin
      for (int j = 0; j < FANOUT; j++) begin
        fan_d[k*FANOUT+j] = ph_d[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ph_q  <= '0;
      phn_q <= '1;
      fan_q <= '0;
    end else begin
      ph_q  <= ph_d;
      phn_q <= ~ph_d;
      fan_q <= fan_d;
    end
  end

  assign ph     = ph_q;
  assign phn    = phn_q;
  assign ph_fan = fan_q;

endmodule

// File: rtl/clock_phase_gen.sv
// Non-overlapping multi-phase clock enable sequencer with bit-time counter,
// run / stop-at-bit-boundary / single-step control and buffered phase copies.
module clock_phase_gen
  import clock_phase_pkg::*;
#(
  parameter int NPHASE    = 4,
  parameter int PHASE_CYC = 3,
  parameter int GAP_CYC   = 1,
  parameter int BIT_TIMES = 14,
  parameter int FANOUT    = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         RUN,
  input  logic                         STEP,
  output logic [NPHASE-1:0]            PH,
  output logic [NPHASE-1:0]            PHN,
  output logic [NPHASE*FANOUT-1:0]     PH_FAN,
  output logic [$clog2(BIT_TIMES)-1:0] BIT_TIME,
  output logic                         BIT_SYNC,
  output logic                         BUSY
);

  localparam int BW = bit_w(BIT_TIMES);
  localparam int CW = cnt_w(PHASE_CYC, GAP_CYC);
  localparam int PW = idx_w(NPHASE);

  localparam logic [CW-1:0] ACT_LAST = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(NPHASE - 1);
  localparam logic [BW-1:0] BT_LAST  = BW'(BIT_TIMES - 1);

  if (!params_ok(NPHASE, PHASE_CYC, GAP_CYC, BIT_TIMES, FANOUT)) begin : g_bad_params
    $error("clock_phase_gen: parameter out of legal range");
  end

  state_e            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sync_q, sync_d;
  logic              busy_q, busy_d;
  logic [NPHASE-1:0] ph_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    unique case (state_q)
      ST_IDLE: begin
        // RUN and STEP together start the same way; only RUN decides continuation.
        if (RUN || STEP) begin
          state_d = ST_ACT;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      ST_ACT: begin
        if (cnt_q == ACT_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (phase_q == PH_LAST) begin
            bit_d   = (bit_q == BT_LAST) ? '0 : bit_q + BW'(1);
            phase_d = '0;
            state_d = RUN ? ST_ACT : ST_IDLE;
          end else begin
            phase_d = phase_q + PW'(1);
            state_d = ST_ACT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they land on the transition edge.
    busy_d = (state_d != ST_IDLE);
    sync_d = (state_d == ST_ACT) && (state_q != ST_ACT) &&
             (phase_d == '0) && (bit_d == '0);
    for (int k = 0; k < NPHASE; k++) begin
      ph_d[k] = (state_d == ST_ACT) && (phase_d == PW'(k));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
    end
  end

  phase_fanout #(
    .NPHASE (NPHASE),
    .FANOUT (FANOUT)
  ) u_fanout (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ph_d   (ph_d),
    .ph     (PH),
    .phn    (PHN),
    .ph_fan (PH_FAN)
  );

  assign BIT_TIME = bit_q;
  assign BIT_SYNC = sync_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Bench for clock_phase_gen: default instance under directed + random control,
// swept instance under random control, both against a position-in-bit model.
module tb_clock_phase_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run0, step0, run1, step1;
  logic [3:0]  ph0, phn0, bt0;
  logic [31:0] fan0;
  logic        sync0, busy0;
  logic [1:0]  ph1, phn1, bt1;
  logic [3:0]  fan1;
  logic        sync1, busy1;

  clock_phase_gen u_dut0 (
    .CLK(clk), .RST_N(rst_n), .RUN(run0), .STEP(step0),
    .PH(ph0), .PHN(phn0), .PH_FAN(fan0), .BIT_TIME(bt0),
    .BIT_SYNC(sync0), .BUSY(busy0)
  );

  clock_phase_gen #(
    .NPHASE(2), .PHASE_CYC(1), .GAP_CYC(2), .BIT_TIMES(3), .FANOUT(2)
  ) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .RUN(run1), .STEP(step1),
    .PH(ph1), .PHN(phn1), .PH_FAN(fan1), .BIT_TIME(bt1),
    .BIT_SYNC(sync1), .BUSY(busy1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Configuration of each instance: phase len, gap len, phases, bit times, fanout.
  int P_C [2] = '{3, 1};
  int G_C [2] = '{1, 2};
  int NP  [2] = '{4, 2};
  int BTS [2] = '{14, 3};
  int FO  [2] = '{8, 2};

  // Model: a running flag, the cycle position inside the bit period and the bit time.
  bit         m_act  [2];
  int         m_pos  [2];
  int         m_bt   [2];
  int         zrun   [2];
  logic [7:0] prev_ph[2];
  int         busy_cnt;

  logic [63:0] g_ph[2], g_phn[2], g_fan[2], g_bt[2];
  logic        g_sync[2], g_busy[2];

  always_comb begin
    g_ph[0]  = 64'(ph0);  g_phn[0] = 64'(phn0); g_fan[0] = 64'(fan0); g_bt[0] = 64'(bt0);
    g_sync[0] = sync0;    g_busy[0] = busy0;
    g_ph[1]  = 64'(ph1);  g_phn[1] = 64'(phn1); g_fan[1] = 64'(fan1); g_bt[1] = 64'(bt1);
    g_sync[1] = sync1;    g_busy[1] = busy1;
  end

  function automatic logic [7:0] exp_ph(input int i);
    int per;
    per = P_C[i] + G_C[i];
    if (m_act[i] && (m_pos[i] % per) < P_C[i]) return 8'(1 << (m_pos[i] / per));
    return 8'h00;
  endfunction

  function automatic logic [63:0] rep(input int i, input logic [7:0] p);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < NP[i]; k++)
      for (int j = 0; j < FO[i]; j++) r[k*FO[i]+j] = p[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_pos[i] = 0; m_bt[i] = 0; zrun[i] = 1000; prev_ph[i] = '0;
    end
  endtask

  task automatic model_edge(input int i, input logic run, input logic step);
    int period;
    period = NP[i] * (P_C[i] + G_C[i]);
    if (!m_act[i]) begin
      if (run || step) begin m_act[i] = 1; m_pos[i] = 0; end
    end else if (m_pos[i] == period - 1) begin
      m_bt[i] = (m_bt[i] + 1) % BTS[i];
      if (run) m_pos[i] = 0; else m_act[i] = 0;
    end else begin
      m_pos[i]++;
    end
  endtask

  task automatic check_dut(input int i);
    logic [7:0]  e;
    logic [63:0] mask;
    e    = exp_ph(i);
    mask = (64'd1 << NP[i]) - 64'd1;
    chk($sformatf("d%0d.ph", i),   g_ph[i],  64'(e));
    chk($sformatf("d%0d.phn", i),  g_phn[i], ~64'(e) & mask);
    chk($sformatf("d%0d.fan", i),  g_fan[i], rep(i, e));
    chk($sformatf("d%0d.bt", i),   g_bt[i],  64'(m_bt[i]));
    chk($sformatf("d%0d.sync", i), 64'(g_sync[i]), 64'(m_act[i] && m_pos[i] == 0 && m_bt[i] == 0));
    chk($sformatf("d%0d.busy", i), 64'(g_busy[i]), 64'(m_act[i]));
    chk($sformatf("d%0d.onehot", i), 64'($countones(g_ph[i]) <= 1), 64'd1);
    if (g_ph[i] != 0) begin
      if (prev_ph[i] == 0) chk($sformatf("d%0d.gap", i), 64'(zrun[i] >= G_C[i]), 64'd1);
      else                 chk($sformatf("d%0d.hold", i), 64'(g_ph[i][7:0] == prev_ph[i]), 64'd1);
      zrun[i] = 0;
    end else begin
      zrun[i]++;
    end
    prev_ph[i] = g_ph[i][7:0];
  endtask

  // One cycle: model follows the sampled inputs, outputs checked at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, run0, step0);
      model_edge(1, run1, step1);
    end
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    if (busy0) busy_cnt++;
    step1 = ($urandom_range(0, 9) == 0);
    if ($urandom_range(0, 19) == 0) run1 = ~run1;
  endtask

  task automatic wait_model(input int bt, input logic [7:0] ph, input string tag);
    int n;
    n = 0;
    while (!(m_bt[0] == bt && exp_ph(0) == ph) && n < 600) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 600), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sync_cnt;
    rst_n = 1'b0; run0 = 1'b0; step0 = 1'b0; run1 = 1'b0; step1 = 1'b0;
    busy_cnt = 0;
    model_reset();
    repeat (2) tick();
    chk("reset_phn", 64'(phn0), 64'hF);
    rst_n = 1'b1;
    tick();

    // Free run: sync at cycle 1 and again one word (224 cycles) later.
    run0 = 1'b1;
    sync_cnt = 0;
    repeat (14 * 16 + 20) begin
      tick();
      if (sync0) sync_cnt++;
    end
    chk("sync_cnt", 64'(sync_cnt), 64'd2);

    // Drop RUN during phase 1 of bit time 5.
    wait_model(5, 8'h02, "wait_bt5");
    run0 = 1'b0;
    repeat (40) tick();
    chk("stop_bt",   64'(bt0),   64'd6);
    chk("stop_busy", 64'(busy0), 64'd0);
    chk("stop_ph",   64'(ph0),   64'd0);

    // Park at bit time 13, then single step through one bit.
    run0 = 1'b1;
    wait_model(12, 8'h01, "wait_bt12");
    run0 = 1'b0;
    repeat (20) tick();
    chk("idle_bt13", 64'(bt0), 64'd13);
    busy_cnt = 0;
    step0 = 1'b1; tick(); step0 = 1'b0;
    repeat (6) tick();
    step0 = 1'b1; tick(); step0 = 1'b0;
    repeat (20) tick();
    chk("step_bt",   64'(bt0),     64'd0);
    chk("step_len",  64'(busy_cnt), 64'd16);
    chk("step_busy", 64'(busy0),   64'd0);

    // Asynchronous reset while phase 2 is active.
    run0 = 1'b1;
    wait_model(m_bt[0], 8'h04, "wait_ph2");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ph",   64'(ph0),   64'd0);
    chk("rst_phn",  64'(phn0),  64'hF);
    chk("rst_bt",   64'(bt0),   64'd0);
    chk("rst_fan",  64'(fan0),  64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    model_reset();
    @(negedge clk);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("restart_ph",   64'(ph0),   64'd1);
    chk("restart_sync", 64'(sync0), 64'd1);

    // Random RUN/STEP traffic on the default instance.
    repeat (1500) begin
      if ($urandom_range(0, 24) == 0) run0 = ~run0;
      step0 = ($urandom_range(0, 11) == 0);
      tick();
    end
    step0 = 1'b0;
    run0  = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
